// File: rtl/up_slave_regs_pkg.sv
// Shared definitions for the uP bus responder: bus widths, register
// addresses and FSM state encodings (also used by the bus model tests).
package up_slave_regs_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL0  = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_CTRL1  = 6'h01;
  localparam logic [ADDR_W-1:0] ADDR_CTRL2  = 6'h02;
  localparam logic [ADDR_W-1:0] ADDR_CTRL3  = 6'h03;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_ERRCNT = 6'h3E;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } upState_e;

endpackage

// File: rtl/up_slave_regs_if.sv
// Host uP bus control/address group; the tristate data bus stays a plain
// inout on the responder so resolution happens at the pin.
interface up_slave_regs_if;
  import up_slave_regs_pkg::*;

  logic [ADDR_W-1:0] up_addr;
  logic              up_cs_n;
  logic              up_rw;

  modport master (output up_addr, output up_cs_n, output up_rw);
  modport slave  (input  up_addr, input  up_cs_n, input  up_rw);

endinterface

// File: rtl/up_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module up_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/up_slave_regs.sv
// uP bus responder: synchronizes chip select, performs one access per
// cs-low period into four control registers, returns status on reads.
// Optional feature macro: UP_SLAVE_ERRCNT_EN (saturating error counter at 6'h3E).
module up_slave_regs
  import up_slave_regs_pkg::*;
#(
  parameter int unsigned       CLK_PERIOD_NS = 10,
  parameter logic [ADDR_W-1:0] STATUS_ADDR   = ADDR_STATUS
) (
  input  logic              clk,
  input  logic              rst_n,
  up_slave_regs_if.slave    bus,
  inout  wire  [DATA_W-1:0] up_data,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] ctrl0,
  output logic [DATA_W-1:0] ctrl1,
  output logic [DATA_W-1:0] ctrl2,
  output logic [DATA_W-1:0] ctrl3,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic csS;

  upState_e                stateQ, stateD;
  logic [ADDR_W-1:0]       addrQ, addrD;
  logic                    rwQ, rwD;
  logic [DATA_W-1:0]       wdataQ, wdataD;
  logic [3:0][DATA_W-1:0]  ctrlQ, ctrlD;
  logic                    wrStrobeQ, wrStrobeD;
  logic [ADDR_W-1:0]       wrAddrQ, wrAddrD;
  logic [DATA_W-1:0]       wrDataQ, wrDataD;
  logic [DATA_W-1:0]       doutQ, doutD;
  logic                    dataOeQ, dataOeD;

  logic                    ctrlHit, statusHit, errHit;
  logic [DATA_W-1:0]       errVal;
  logic [DATA_W-1:0]       readVal;

  // Chip select sync; resets to "asserted" so an in-flight cycle is skipped.
  up_sync2 #(.RST_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.up_cs_n),
    .q     (csS)
  );

  assign ctrlHit   = (addrQ[ADDR_W-1:2] == 4'd0);
  assign statusHit = (addrQ == STATUS_ADDR);

`ifdef UP_SLAVE_ERRCNT_EN
  logic [DATA_W-1:0] errCntQ, errCntD;
  logic              badAccess;

  assign errHit    = (addrQ == ADDR_ERRCNT);
  assign errVal    = errCntQ;
  assign badAccess = rwQ ? !(ctrlHit || statusHit || errHit)
                         : !(ctrlHit || errHit);

  // Error counter next value: clear on write to its address, else saturate-count.
  always_comb begin
    errCntD = errCntQ;
    if (stateQ == ST_ACCESS) begin
      if (!rwQ && errHit) begin
        errCntD = '0;
      end else if (badAccess && (errCntQ != 8'hFF)) begin
        errCntD = errCntQ + 8'd1;
      end
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) errCntQ <= '0;
    else        errCntQ <= errCntD;
  end
`else
  assign errHit = 1'b0;
  assign errVal = '0;
`endif

  // Read data select for the captured address.
  always_comb begin
    readVal = '0;
    if (ctrlHit)        readVal = ctrlQ[addrQ[1:0]];
    else if (statusHit) readVal = status_in;
    else if (errHit)    readVal = errVal;
  end

  // Next-state and register updates for the access FSM.
  always_comb begin
    stateD    = stateQ;
    addrD     = addrQ;
    rwD       = rwQ;
    wdataD    = wdataQ;
    ctrlD     = ctrlQ;
    wrStrobeD = 1'b0;
    wrAddrD   = wrAddrQ;
    wrDataD   = wrDataQ;
    doutD     = doutQ;
    dataOeD   = dataOeQ;
    case (stateQ)
      ST_IDLE: begin
        if (!csS) begin
          addrD  = bus.up_addr;
          rwD    = bus.up_rw;
          wdataD = up_data;
          stateD = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stateD = ST_HOLD;
        if (rwQ) begin
          doutD   = readVal;
          dataOeD = 1'b1;
        end else if (ctrlHit || errHit) begin
          if (ctrlHit) ctrlD[addrQ[1:0]] = wdataQ;
          wrStrobeD = 1'b1;
          wrAddrD   = addrQ;
          wrDataD   = wdataQ;
        end
      end
      ST_HOLD: begin
        if (csS) begin
          stateD  = ST_IDLE;
          dataOeD = 1'b0;
        end
      end
      default: stateD = ST_HOLD;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= ST_HOLD;
      addrQ     <= '0;
      rwQ       <= 1'b0;
      wdataQ    <= '0;
      ctrlQ     <= '0;
      wrStrobeQ <= 1'b0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      doutQ     <= '0;
      dataOeQ   <= 1'b0;
    end else begin
      stateQ    <= stateD;
      addrQ     <= addrD;
      rwQ       <= rwD;
      wdataQ    <= wdataD;
      ctrlQ     <= ctrlD;
      wrStrobeQ <= wrStrobeD;
      wrAddrQ   <= wrAddrD;
      wrDataQ   <= wrDataD;
      doutQ     <= doutD;
      dataOeQ   <= dataOeD;
    end
  end

  assign up_data   = dataOeQ ? doutQ : 8'hzz;
  assign ctrl0     = ctrlQ[0];
  assign ctrl1     = ctrlQ[1];
  assign ctrl2     = ctrlQ[2];
  assign ctrl3     = ctrlQ[3];
  assign wr_strobe = wrStrobeQ;
  assign wr_addr   = wrAddrQ;
  assign wr_data   = wrDataQ;

  // Never drive the bus during a write; clock must meet bus timing.
  a_no_contend: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(dataOeQ && !rwQ));
  a_clk_period: assert property (@(posedge clk) CLK_PERIOD_NS <= 32'd10);

endmodule
